// File: rtl/count_arb_if.sv
// Bundle between count_arb, its two requesters and the shared counter.
// master: requesters plus counter; slave: the arbiter.
interface count_arb_if #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 6,
    parameter int LEN_W = 6
);
    logic             req0;
    logic             req1;
    logic [IN_W-1:0]  start0;
    logic [IN_W-1:0]  start1;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [OUT_W-1:0] result;
    logic             busy;
    logic [IN_W-1:0]  cnt_in;
    logic             cnt_load;
    logic             cnt_enable;
    logic [OUT_W-1:0] cnt_out;

    modport master (
        output req0, req1, start0, start1, len0, len1, cnt_out,
        input  gnt0, gnt1, done0, done1, result, busy,
        input  cnt_in, cnt_load, cnt_enable
    );

    modport slave (
        input  req0, req1, start0, start1, len0, len1, cnt_out,
        output gnt0, gnt1, done0, done1, result, busy,
        output cnt_in, cnt_load, cnt_enable
    );
endinterface

// File: rtl/count_arb.sv
// Round-robin arbiter/sequencer for a shared loadable counter:
// grant, load start value, count len cycles, return the final value.
module count_arb #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 6,
    parameter int LEN_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    count_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_n;
    logic             owner, owner_n;
    logic             last, last_n;
    logic [IN_W-1:0]  start_q, start_n;
    logic [LEN_W-1:0] remain, remain_n;
    logic [OUT_W-1:0] result_q, result_n;
    logic             gnt0_n, gnt1_n;
    logic             done0_n, done1_n;
    logic             pick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            start_q   <= '0;
            remain    <= '0;
            result_q  <= '0;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            start_q   <= start_n;
            remain    <= remain_n;
            result_q  <= result_n;
            bus.gnt0  <= gnt0_n;
            bus.gnt1  <= gnt1_n;
            bus.done0 <= done0_n;
            bus.done1 <= done1_n;
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        last_n   = last;
        start_n  = start_q;
        remain_n = remain;
        result_n = result_q;
        gnt0_n   = 1'b0;
        gnt1_n   = 1'b0;
        done0_n  = 1'b0;
        done1_n  = 1'b0;
        // on a tie the requester that did not go last wins
        pick     = bus.req1 && (!bus.req0 || !last);
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_n  = pick;
                    start_n  = pick ? bus.start1 : bus.start0;
                    remain_n = pick ? bus.len1 : bus.len0;
                    gnt0_n   = !pick;
                    gnt1_n   = pick;
                    state_n  = LOAD;
                end
            end
            LOAD: begin
                state_n = (remain != '0) ? RUN : DONE;
            end
            RUN: begin
                remain_n = remain - LEN_W'(1);
                if (remain == LEN_W'(1))
                    state_n = DONE;
            end
            DONE: begin
                result_n = bus.cnt_out;
                done0_n  = !owner;
                done1_n  = owner;
                last_n   = owner;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.cnt_in     = start_q;
    assign bus.cnt_load   = (state == LOAD);
    assign bus.cnt_enable = (state == RUN);
    assign bus.busy       = (state != IDLE);
    assign bus.result     = result_q;
endmodule

// File: tb/tb_count_arb.sv
// Bench for count_arb: directed job table, corner sequences, and a
// random phase checked against a job-level timing model.
module tb_count_arb;
    localparam int N = 2000;
    localparam int M = N + 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    count_arb_if bus ();

    count_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // external shared counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.cnt_out <= '0;
        else if (bus.cnt_load)
            bus.cnt_out <= {1'b0, bus.cnt_in};
        else if (bus.cnt_enable)
            bus.cnt_out <= bus.cnt_out + 6'd1;
    end

    typedef struct {
        bit         idx;
        logic [4:0] st;
        logic [5:0] ln;
        logic [5:0] res;
    } vec_t;

    vec_t vt [6];

    bit         e_gnt  [2][M];
    bit         e_done [2][M];
    bit         e_busy [M];
    bit         e_load [M];
    bit         e_en   [M];
    logic [5:0] e_res  [M];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                bus.busy, bus.cnt_load, bus.cnt_enable};
    endfunction

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = !bus.busy && !bus.done0 && !bus.done1;
        end
        chk({nm, "_idle"}, 32'(ok), 1);
    endtask

    task automatic run_job(input bit idx, input logic [4:0] st,
                           input logic [5:0] ln, input logic [5:0] res,
                           input int n);
        int  n_en = 0;
        int  n_busy = 1;
        int  n_load = 1;
        int  cyc = 0;
        int  dcyc = -1;
        logic [5:0] got = '0;
        string nm;
        nm = $sformatf("job%0d", n);
        if (idx) begin
            bus.req1 = 1'b1; bus.start1 = st; bus.len1 = ln;
        end else begin
            bus.req0 = 1'b1; bus.start0 = st; bus.len0 = ln;
        end
        @(posedge clk); #1;
        chk({nm, "_gnt"}, 32'({bus.gnt0, bus.gnt1}),
            idx ? 32'd1 : 32'd2);
        chk({nm, "_load"}, 32'(bus.cnt_load), 1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 0; i < int'(ln) + 4 && dcyc < 0; i++) begin
            @(posedge clk); #1;
            cyc++;
            n_en   += int'(bus.cnt_enable);
            n_busy += int'(bus.busy);
            n_load += int'(bus.cnt_load);
            if (idx ? bus.done1 : bus.done0) begin
                dcyc = cyc;
                got  = bus.result;
            end
        end
        chk({nm, "_done_cyc"}, 32'(dcyc), 32'(int'(ln) + 2));
        chk({nm, "_result"}, 32'(got), 32'(res));
        chk({nm, "_en_cycles"}, 32'(n_en), 32'(ln));
        chk({nm, "_busy_cycles"}, 32'(n_busy), 32'(int'(ln) + 2));
        chk({nm, "_load_cycles"}, 32'(n_load), 1);
        @(posedge clk); #1;
        chk({nm, "_result_hold"}, 32'(bus.result), 32'(res));
    endtask

    initial begin
        int ng, g1c, d0c, both, cyc, nd0, nd1, ngt1;
        int free_at, st, ln, jend;
        bit last_m, idx;
        logic [5:0] cur_res;
        logic [5:0] r1;
        bit order [8];

        vt[0] = '{1'b0, 5'd5,  6'd3,  6'd8};
        vt[1] = '{1'b1, 5'd17, 6'd0,  6'd17};
        vt[2] = '{1'b0, 5'd31, 6'd40, 6'd7};
        vt[3] = '{1'b1, 5'd0,  6'd63, 6'd63};
        vt[4] = '{1'b0, 5'd31, 6'd63, 6'd30};
        vt[5] = '{1'b1, 5'd10, 6'd1,  6'd11};

        bus.req0 = 0; bus.req1 = 0;
        bus.start0 = 0; bus.start1 = 0;
        bus.len0 = 0; bus.len1 = 0;
        #12;
        chk("reset_ctl", 32'(ctl()), 0);
        chk("reset_result", 32'(bus.result), 0);

        // both requesting out of reset
        bus.req0 = 1; bus.req1 = 1;
        bus.start0 = 5'd1; bus.len0 = 6'd2;
        bus.start1 = 5'd2; bus.len1 = 6'd1;
        @(negedge clk);
        rst = 0;
        ng = 0; g1c = -1; d0c = -1; both = 0; cyc = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.gnt0 && bus.gnt1) both++;
            if (bus.done0 && bus.done1) both++;
            if (bus.gnt0) order[ng++] = 1'b0;
            if (bus.gnt1) begin
                if (g1c < 0) g1c = cyc;
                order[ng++] = 1'b1;
            end
            if (bus.done0 && d0c < 0) d0c = cyc;
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("alt_ngrants", 32'(ng), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt_order%0d", i), 32'(order[i]), 32'(i % 2));
        chk("alt_gnt1_after_done0", 32'(g1c), 32'(d0c + 1));
        chk("alt_no_double", 32'(both), 0);
        wait_idle("alt");

        for (int i = 0; i < 6; i++)
            run_job(vt[i].idx, vt[i].st, vt[i].ln, vt[i].res, i);

        // reset in the middle of a RUN
        bus.req0 = 1; bus.start0 = 5'd3; bus.len0 = 6'd20;
        @(posedge clk); #1;
        chk("mid_gnt0", 32'(bus.gnt0), 1);
        bus.req0 = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_running", 32'(bus.cnt_enable), 1);
        bus.req1 = 1; bus.start1 = 5'd9; bus.len1 = 6'd2;
        #2 rst = 1;
        #1;
        chk("mid_rst_ctl", 32'(ctl()), 0);
        chk("mid_rst_result", 32'(bus.result), 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_gnt", 32'({bus.gnt0, bus.gnt1}), 1);
        bus.req1 = 0;
        nd0 = 0; nd1 = 0; r1 = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            nd0 += int'(bus.done0);
            if (bus.done1) begin
                nd1++;
                r1 = bus.result;
            end
        end
        chk("post_rst_no_done0", 32'(nd0), 0);
        chk("post_rst_done1", 32'(nd1), 1);
        chk("post_rst_result", 32'(r1), 11);

        // req1 only visible during LOAD
        bus.req0 = 1; bus.start0 = 5'd4; bus.len0 = 6'd4;
        @(posedge clk); #1;
        chk("pulse_gnt0", 32'(bus.gnt0), 1);
        bus.req0 = 0;
        bus.req1 = 1;
        @(posedge clk); #1;
        bus.req1 = 0;
        ngt1 = 0; nd0 = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            ngt1 += int'(bus.gnt1);
            nd0  += int'(bus.done0);
        end
        chk("pulse_no_gnt1", 32'(ngt1), 0);
        chk("pulse_done0", 32'(nd0), 1);

        // random phase against the job-level model
        rst = 1;
        @(negedge clk);
        rst = 0;
        free_at = 1; last_m = 1'b1; cur_res = '0;
        for (int k = 1; k <= N; k++) begin
            if ($urandom_range(0, 3) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 3) == 0) bus.req1 = ~bus.req1;
            bus.start0 = 5'($urandom);
            bus.start1 = 5'($urandom);
            bus.len0 = ($urandom_range(0, 7) == 0) ?
                6'($urandom) : 6'($urandom_range(0, 6));
            bus.len1 = ($urandom_range(0, 7) == 0) ?
                6'($urandom) : 6'($urandom_range(0, 6));
            if (k >= free_at && (bus.req0 || bus.req1)) begin
                if (bus.req0 && bus.req1) idx = !last_m;
                else idx = bus.req1;
                st = idx ? int'(bus.start1) : int'(bus.start0);
                ln = idx ? int'(bus.len1) : int'(bus.len0);
                jend = k + 2 + ln;
                e_gnt[idx][k] = 1'b1;
                e_load[k] = 1'b1;
                for (int j = k; j < jend; j++) e_busy[j] = 1'b1;
                for (int j = k + 1; j <= k + ln; j++) e_en[j] = 1'b1;
                e_done[idx][jend] = 1'b1;
                e_res[jend] = 6'((st + ln) % 64);
                free_at = jend + 1;
                last_m = idx;
            end
            @(posedge clk); #1;
            if (e_done[0][k] || e_done[1][k]) cur_res = e_res[k];
            chk($sformatf("rand_ctl@%0d", k), 32'(ctl()),
                32'({e_gnt[0][k], e_gnt[1][k], e_done[0][k],
                     e_done[1][k], e_busy[k], e_load[k], e_en[k]}));
            chk($sformatf("rand_result@%0d", k), 32'(bus.result),
                32'(cur_res));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/count_arb.md
# count_arb

Two-requester round-robin arbiter and sequencer for the shared 5-bit-load / 6-bit-output loadable counter. It grants the counter to one requester at a time, loads that requester's start value, and enables counting for the requested number of cycles. It then returns the final count with a one-cycle done pulse. It sits between the requesting control blocks and the counter's `cntin`/`load`/`enable`/`cntout` pins.

## Interface
- `IN_W`, default 5: counter load width.
- `OUT_W`, default 6: counter output width.
- `LEN_W`, default 6: count-length width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: request; held until the matching grant.
- `start0`, `start1` in IN_W: start value; sampled at the grant edge.
- `len0`, `len1` in LEN_W: number of enable cycles; sampled at the grant edge.
- `gnt0`, `gnt1` out 1: one-cycle grant pulse.
- `done0`, `done1` out 1: one-cycle completion pulse.
- `result` out OUT_W: final counter value, valid while a `done` is high.
- `busy` out 1: high in any state except IDLE.
- `cnt_in` out IN_W: drives counter `cntin`.
- `cnt_load` out 1: drives counter `load`.
- `cnt_enable` out 1: drives counter `enable`.
- `cnt_out` in OUT_W: from counter `cntout`.

## Operation
- Counter contract, shared `clk`/`rst`:
  - `load` has priority and loads {0,`cntin`}.
  - Otherwise `enable` increments modulo 2^OUT_W.
- FSM states: IDLE, LOAD, RUN, DONE. Registers: `owner`, `last` (last granted index), `start_q`, `remain` (LEN_W).
- IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the index != `last`.
  - On grant: `gnt<owner>`<=1, `start_q`<=start, `remain`<=len, `owner`<=index, go to LOAD.
  - No request pending: stay in IDLE.
- LOAD:
  - `cnt_load`=1, `cnt_enable`=0, `cnt_in`=`start_q`.
  - Next state: RUN if `remain`!=0, else DONE.
- RUN:
  - `cnt_enable`=1, `cnt_load`=0, `remain` decrements each cycle.
  - When `remain`==1, go to DONE.
- DONE:
  - `cnt_enable`=0. At the exit edge: `result`<=`cnt_out`, `done<owner>`<=1, `last`<=`owner`, go to IDLE.
- `cnt_load`/`cnt_enable` are decoded from the state register only.
- `cnt_in`=`start_q` in all states.
- `gnt*`/`done*` are registered and self-clear after one cycle.
- `result` holds its value until the next DONE exit.
- Requests are not queued:
  - A request dropped before its grant is withdrawn.
  - A request held through its own done cycle is a new request.
  - Requests arriving in LOAD/RUN/DONE wait; they are evaluated only in IDLE.
- Arithmetic: `result` = (start + len) mod 2^OUT_W. Wrap is reachable with LEN_W=6, e.g. 31+40 -> 7.

## Timing
- Request sampled high in IDLE cycle T:
  - `gnt` and LOAD in cycle T+1.
  - RUN in T+2..T+1+len.
  - DONE in T+2+len.
  - `done`/`result` valid in T+3+len.
  - len=0: DONE in T+2, `done` in T+3.
- The `done` cycle is an IDLE cycle, so a new grant edge can occur at its end. Back-to-back jobs have gnt-to-gnt spacing of len+3 cycles.
- Reset (async, any state):
  - State IDLE, `last`=1 (req0 wins the first tie).
  - `owner`=0, `start_q`=0, `remain`=0, `result`=0.
  - All `gnt`/`done`=0, `busy`=0, `cnt_load`=0, `cnt_enable`=0.
  - An in-flight job is lost with no done pulse.
- Simultaneous req0/req1 in the same cycle: arbitration by `last` only; never two grants.
- Never two `done` pulses in the same cycle.

## Test plan
- req0 only, start0=5, len0=3:
  - gnt0 at T+1, cnt_load high 1 cycle, cnt_enable high 3 cycles.
  - done0 at T+6 with result=8.
  - busy high for 5 cycles (T+1..T+5).
- req0 and req1 both high from reset:
  - gnt0 first; gnt1 in the cycle after done0.
  - With both held, grants alternate 0,1,0,1.
- len1=0, start1=17: cnt_enable never high; done1 at T+3 with result=17.
- start0=31, len0=40: result=7, showing 6-bit wrap.
- rst asserted mid-RUN:
  - All outputs 0 immediately and state IDLE; no done pulse follows.
  - After release, req1 pending alone is granted next.
- req1 pulsed during LOAD and dropped before IDLE: no gnt1 is ever issued.
